// File: rtl/rf_writeback_arbiter.sv
// rtl/rf_writeback_arbiter.sv - register-file write port arbiter (ALU vs LSU FIFO) with starvation guard and busy scoreboard
module rf_writeback_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alu_valid,
    input  logic [4:0]             alu_rd,
    input  logic [31:0]            alu_data,
    output logic                   alu_stall,
    input  logic                   lsu_valid,
    output logic                   lsu_ready,
    input  logic [4:0]             lsu_rd,
    input  logic [31:0]            lsu_data,
    input  logic                   iss_valid,
    input  logic [4:0]             iss_rd,
    output logic                   rf_we,
    output logic [4:0]             rf_rd,
    output logic [31:0]            rf_data,
    output logic [31:0]            busy_mask,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);

    logic [4:0]    fifo_rd   [DEPTH];
    logic [31:0]   fifo_data [DEPTH];
    logic [AW-1:0] rptr;
    logic [AW-1:0] wptr;
    logic [SW-1:0] starve;

    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          take_alu;
    logic          commit;
    logic [4:0]    head_rd;
    logic [31:0]   head_data;
    logic [4:0]    sel_rd;
    logic [31:0]   sel_data;
    logic [31:0]   busy_next;

    // Ready and stall look only at registered state so neither depends on same-cycle inputs.
    assign fifo_empty = (fifo_count == '0);
    assign lsu_ready  = (fifo_count < FULL_COUNT);
    assign alu_stall  = (starve == STARVE_LIM) && !fifo_empty;
    assign push       = lsu_valid && lsu_ready;
    assign pop        = alu_stall || (!alu_valid && !fifo_empty);
    assign take_alu   = alu_valid && !alu_stall;
    assign commit     = pop || take_alu;
    assign head_rd    = fifo_rd[rptr];
    assign head_data  = fifo_data[rptr];

    // Pick the winning result for this cycle's commit.
    always_comb begin
        sel_rd   = alu_rd;
        sel_data = alu_data;
        if (pop) begin
            sel_rd   = head_rd;
            sel_data = head_data;
        end
    end

    // Scoreboard update: the clear is applied first so a same-cycle issue re-sets the bit.
    always_comb begin
        busy_next = busy_mask;
        if (pop && (head_rd != 5'd0)) begin
            busy_next[head_rd] = 1'b0;
        end
        if (iss_valid && (iss_rd != 5'd0)) begin
            busy_next[iss_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // FIFO storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wptr]   <= lsu_rd;
            fifo_data[wptr] <= lsu_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            rptr       <= '0;
            wptr       <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (AW + 1)'(1);
                2'b01:   fifo_count <= fifo_count - (AW + 1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Count consecutive ALU wins over a waiting LSU entry, saturating at the stall threshold.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve <= '0;
        end else if (pop || fifo_empty) begin
            starve <= '0;
        end else if (take_alu && (starve != STARVE_LIM)) begin
            starve <= starve + SW'(1);
        end
    end

    // Registered write port; a commit to x0 is consumed but never raises the enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we   <= 1'b0;
            rf_rd   <= 5'd0;
            rf_data <= 32'd0;
        end else begin
            rf_we <= commit && (sel_rd != 5'd0);
            if (commit) begin
                rf_rd   <= sel_rd;
                rf_data <= sel_data;
            end
        end
    end

    // Pending-destination scoreboard register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_mask <= 32'd0;
        end else begin
            busy_mask <= busy_next;
        end
    end

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// tb/tb_rf_writeback_arbiter.sv - self-checking bench for rf_writeback_arbiter
module tb_rf_writeback_arbiter;

    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = 5'd0;
    logic [31:0] alu_data = 32'd0;
    logic        alu_stall;
    logic        lsu_valid = 1'b0;
    logic        lsu_ready;
    logic [4:0]  lsu_rd = 5'd0;
    logic [31:0] lsu_data = 32'd0;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_rd = 5'd0;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data;
    logic [31:0] busy_mask;
    logic [$clog2(DEPTH):0] fifo_count;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    rf_writeback_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data),
        .busy_mask(busy_mask), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    // Reference model: queue of pending LSU results, wait counter, busy bits, expected write port.
    entry_t      m_q[$];
    int          m_starve = 0;
    logic [31:0] m_busy = 32'd0;
    logic        m_we = 1'b0;
    logic [4:0]  m_rd = 5'd0;
    logic [31:0] m_data = 32'd0;
    int          t_n;
    bit          t_stall;
    bit          t_fifo;
    bit          t_alu;
    entry_t      t_hd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_starve = 0;
            m_busy   = 32'd0;
            m_we     = 1'b0;
            m_rd     = 5'd0;
            m_data   = 32'd0;
        end else begin
            t_n     = m_q.size();
            t_stall = (m_starve == STARVE_MAX) && (t_n > 0);
            t_fifo  = t_stall || (!alu_valid && t_n > 0);
            t_alu   = alu_valid && !t_stall;
            m_we    = 1'b0;
            if (t_fifo) begin
                t_hd   = m_q.pop_front();
                m_we   = (t_hd.rd != 0);
                m_rd   = t_hd.rd;
                m_data = t_hd.data;
                if (t_hd.rd != 0) m_busy[t_hd.rd] = 1'b0;
            end else if (t_alu) begin
                m_we   = (alu_rd != 0);
                m_rd   = alu_rd;
                m_data = alu_data;
            end
            if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
            if (t_fifo || t_n == 0) m_starve = 0;
            else if (t_alu && m_starve < STARVE_MAX) m_starve = m_starve + 1;
            if (lsu_valid && t_n < DEPTH) m_q.push_back({lsu_rd, lsu_data});
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("rf_we", rf_we, m_we);
            if (m_we) begin
                chk("rf_rd", rf_rd, m_rd);
                chk("rf_data", rf_data, m_data);
            end
            chk("busy_mask", busy_mask, m_busy);
            chk("fifo_count", fifo_count, m_q.size());
            chk("lsu_ready", lsu_ready, m_q.size() < DEPTH);
            chk("alu_stall", alu_stall, (m_starve == STARVE_MAX) && (m_q.size() > 0));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        iss_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with random inputs.
        for (int i = 0; i < 3; i++) begin
            rst = 1'b1;
            alu_valid = 1'($urandom); alu_rd = 5'($urandom); alu_data = $urandom;
            lsu_valid = 1'($urandom); lsu_rd = 5'($urandom); lsu_data = $urandom;
            iss_valid = 1'($urandom); iss_rd = 5'($urandom);
            step();
            cmp_en = 1'b1;
        end
        rst = 1'b0;
        idle();
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_rd", rf_rd, 0);
        chk("rst_rf_data", rf_data, 0);
        chk("rst_busy", busy_mask, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ready", lsu_ready, 1);
        step();
        chk("post_rst_ready", lsu_ready, 1);
        chk("post_rst_we", rf_we, 0);

        // ALU path.
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h0000_1234;
        step();
        chk("alu_we", rf_we, 1);
        chk("alu_rd", rf_rd, 5);
        chk("alu_data", rf_data, 32'h1234);
        alu_rd = 5'd0; alu_data = 32'hDEAD_0000;
        step();
        chk("alu_x0_we", rf_we, 0);
        idle();
        step();

        // FIFO fill with ALU busy, then in-order drain.
        for (int i = 1; i <= 4; i++) begin
            alu_valid = 1'b1; alu_rd = 5'd20; alu_data = $urandom;
            lsu_valid = 1'b1; lsu_rd = 5'(i); lsu_data = 32'hA0 + i;
            step();
        end
        chk("full_ready", lsu_ready, 0);
        chk("full_count", fifo_count, 4);
        chk("full_stall", alu_stall, 1);
        lsu_rd = 5'd5; lsu_data = 32'hA5;
        step();
        chk("drain_we_1", rf_we, 1);
        chk("drain_rd_1", rf_rd, 1);
        chk("drain_data_1", rf_data, 32'hA1);
        alu_valid = 1'b0;
        step();
        lsu_valid = 1'b0;
        for (int k = 2; k <= 5; k++) begin
            chk("drain_we", rf_we, 1);
            chk("drain_rd", rf_rd, k);
            chk("drain_data", rf_data, 32'hA0 + k);
            step();
        end
        chk("drain_idle_we", rf_we, 0);
        chk("drain_empty", fifo_count, 0);

        // Starvation guard.
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'hBEEF;
        step();
        lsu_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            chk("starve_nostall", alu_stall, 0);
            alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h100 + i;
            step();
            chk("starve_alu_rd", rf_rd, 10);
            chk("starve_alu_data", rf_data, 32'h100 + i);
        end
        chk("starve_stall", alu_stall, 1);
        alu_data = 32'h104;
        step();
        chk("starve_lsu_rd", rf_rd, 7);
        chk("starve_lsu_data", rf_data, 32'hBEEF);
        chk("starve_release", alu_stall, 0);
        step();
        chk("starve_held_rd", rf_rd, 10);
        chk("starve_held_data", rf_data, 32'h104);
        idle();
        step();

        // Scoreboard set, clear, and same-cycle set-wins.
        iss_valid = 1'b1; iss_rd = 5'd9;
        step();
        iss_valid = 1'b0;
        chk("sb_set", busy_mask[9], 1);
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h99;
        step();
        lsu_valid = 1'b0;
        chk("sb_still_set", busy_mask[9], 1);
        step();
        chk("sb_clear", busy_mask[9], 0);
        chk("sb_commit_rd", rf_rd, 9);
        iss_valid = 1'b1; lsu_valid = 1'b1; lsu_data = 32'h98;
        step();
        lsu_valid = 1'b0;
        step();
        chk("sb_setwins", busy_mask[9], 1);
        chk("sb_setwins_data", rf_data, 32'h98);
        idle();
        step();

        // Reset in the middle of activity.
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1'b1; alu_rd = 5'd21; alu_data = $urandom;
            lsu_valid = 1'b1; lsu_rd = 5'(9 + i); lsu_data = $urandom;
            iss_valid = 1'b1; iss_rd = 5'(9 + i);
            step();
        end
        idle();
        chk("mid_count", fifo_count, 3);
        chk("mid_busy", busy_mask, 32'h0000_0E00);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_busy", busy_mask, 0);
        chk("mid_rst_we", rf_we, 0);
        step();
        step();
        chk("mid_rst_stale_we", rf_we, 0);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 299) == 0);
            alu_valid = ($urandom_range(0, 99) < 55);
            alu_rd    = 5'($urandom);
            alu_data  = $urandom;
            lsu_valid = ($urandom_range(0, 99) < 45);
            lsu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            lsu_data  = $urandom;
            iss_valid = ($urandom_range(0, 99) < 30);
            iss_rd    = 5'($urandom);
            step();
        end
        rst = 1'b0;
        idle();
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_writeback_arbiter.md
# rf_writeback_arbiter

Write-side master for the pipeline register file. Merges single-cycle ALU results and long-latency LSU/load results into the single register-file write port (`WriteEnable`/`rd`/`data`). Buffers LSU results in a small FIFO and guarantees the LSU forward progress with a starvation counter. Keeps a pending-destination scoreboard that the decode stage reads for load-use stalls.

## Interface
Parameters:
- `DEPTH`, 4: LSU result FIFO entries (power of two, ≥2).
- `STARVE_MAX`, 3: consecutive ALU-won cycles with a non-empty FIFO before the ALU is stalled.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `alu_valid`  in  1  ALU result present this cycle.
- `alu_rd`  in  5  ALU destination register.
- `alu_data`  in  32  ALU result.
- `alu_stall`  out  1  combinational; when 1, the ALU result is not consumed and upstream holds it.
- `lsu_valid`  in  1  LSU result offered.
- `lsu_ready`  out  1  FIFO can accept; a transfer happens when `lsu_valid && lsu_ready`.
- `lsu_rd`  in  5  LSU destination register.
- `lsu_data`  in  32  LSU result.
- `iss_valid`  in  1  a long-latency instruction is issuing.
- `iss_rd`  in  5  its destination register.
- `rf_we`  out  1  registered write enable to the register file.
- `rf_rd`  out  5  registered write address.
- `rf_data`  out  32  registered write data.
- `busy_mask`  out  32  scoreboard; bit r = 1 means an LSU write to xr is outstanding.
- `fifo_count`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- **Reset:** `rf_we`=0, `rf_rd`=0, `rf_data`=0, `busy_mask`=0, FIFO empty (`fifo_count`=0), starvation counter=0. Reset mid-operation drops all queued entries and pending bits.
- **Per-cycle commit select**, at most one commit per cycle, in this priority order:
  1. `alu_stall`=1: commit the FIFO head.
  2. `alu_valid`=1: commit the ALU result.
  3. FIFO non-empty: commit the FIFO head.
  4. Otherwise: idle.
- **`alu_stall`** = (starvation counter == `STARVE_MAX`) && FIFO non-empty.
- **Starvation counter:**
  - Increments when the ALU commits while the FIFO is non-empty.
  - Clears to 0 on any FIFO commit or when the FIFO is empty.
  - Saturates at `STARVE_MAX`.
- **Commit:**
  - Next `rf_rd`/`rf_data` take the selected rd/data.
  - `rf_we`=1 only when the selected rd ≠ 0.
  - A committed rd=0 is consumed (FIFO pops) but produces no write; it still clears nothing.
- **FIFO:**
  - Circular buffer with read and write pointers of width $clog2(DEPTH) that wrap modulo `DEPTH`.
  - Enqueue on `lsu_valid && lsu_ready`; dequeue on a FIFO commit.
  - Simultaneous enqueue and dequeue leaves the count unchanged.
  - `lsu_ready` = (`fifo_count` < `DEPTH`), computed from the registered count only. A full FIFO that pops this cycle still reports not-ready.
- **Scoreboard:**
  - Set bit `iss_rd` when `iss_valid` && `iss_rd` ≠ 0.
  - Clear bit rd when a FIFO entry with rd ≠ 0 commits.
  - Simultaneous set and clear of the same bit: set wins (the new issue is outstanding).
  - Bit 0 is always 0. ALU commits never touch the scoreboard.
- **WAW between ALU and pending LSU** for the same rd is excluded by the issue stage stalling on `busy_mask`. This block does not check it.

## Timing
- ALU result accepted in cycle N → `rf_we`/`rf_rd`/`rf_data` valid in cycle N+1 for exactly one cycle (unless another commit follows).
- LSU result enqueued in cycle N into an empty FIFO with no ALU traffic → head commit decision in N+1 → `rf_we` in N+2. Minimum LSU latency is 2 cycles.
- The register file writes on the falling edge. A value presented on `rf_*` in cycle K is readable by a read port sampled at the rising edge of K+1.
- `busy_mask` is registered and updates one cycle after the set or clear event.
- Steady state: one commit per cycle. FIFO entries commit in arrival order.

## Test plan
- **Reset values:** hold `rst`=1 with random inputs for 3 cycles → `rf_we`=0, `busy_mask`=0, `fifo_count`=0, `lsu_ready`=1 the cycle after release.
- **ALU path:** ALU writes x5=0x0000_1234 in cycle 10 → `rf_we`=1, `rf_rd`=5, `rf_data`=0x1234 in cycle 11. ALU write to x0 → `rf_we`=0.
- **FIFO full and in-order drain:**
  - With the ALU busy, offer LSU results x1..x5 = 0xA1..0xA5 on consecutive cycles → `lsu_ready`=0 after 4 accepts; the x5 offer is held.
  - After the ALU goes idle, commits appear as x1,x2,x3,x4,x5 on consecutive cycles.
- **Starvation:**
  - Push one LSU entry (x7=0xBEEF), then assert `alu_valid` every cycle → the ALU wins 3 cycles.
  - 4th cycle: `alu_stall`=1 and x7=0xBEEF commits.
  - Next cycle: the held ALU result commits and the counter is back at 0.
- **Scoreboard:**
  - `iss_rd`=9 issues → `busy_mask[9]`=1 next cycle. LSU x9 commits → bit 9 clears the cycle after.
  - Same-cycle x9 issue and x9 commit → bit 9 stays 1.
- **Reset mid-operation:** with 3 FIFO entries and `busy_mask`=0x0000_0E00, pulse `rst` for one cycle → FIFO empty, `busy_mask`=0, and no stale `rf_we` afterwards.
